// File: rtl/lagarto_wb_pkg.sv
// Shared definitions for the integer writeback arbiter.
//   WORD_W            default register file word width
//   STARVE_LIMIT_DEF  default number of denied cycles before a source is boosted
//   wb_src_e          source encoding carried on grant_src (debug/trace)
//   first_req()       fixed-priority pick, bit 0 (MEM) highest, bit 2 (ALU) lowest
package lagarto_wb_pkg;

  localparam int WORD_W           = 64;
  localparam int STARVE_LIMIT_DEF = 3;
  localparam int NUM_SRC          = 3;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_MUL  = 2'd2,
    SRC_ALU  = 2'd3
  } wb_src_e;

  // Request vector order is {alu, mul, mem}; the result is one-hot or zero.
  function automatic logic [NUM_SRC-1:0] first_req(input logic [NUM_SRC-1:0] req);
    first_req = '0;
    if (req[0])      first_req = 3'b001;
    else if (req[1]) first_req = 3'b010;
    else if (req[2]) first_req = 3'b100;
  endfunction

endpackage

// File: rtl/wb_starve_counter.sv
// Saturating wait counter for one writeback producer.
// Counts cycles in which the producer is valid but not granted; a source that
// has waited STARVE_LIMIT such cycles raises 'boosted'.
// Ports:
//   CLK, RST  clock, synchronous active-high reset (clears the count)
//   lock      pipeline freeze; the count holds while high
//   valid     producer has a result
//   ready     producer was granted this cycle
//   boosted   count has reached STARVE_LIMIT (registered, no comb path from ready)
module wb_starve_counter
  import lagarto_wb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic lock,
  input  logic valid,
  input  logic ready,
  output logic boosted
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;

  // lock has priority over clearing: a frozen pipeline neither ages nor
  // forgets how long a source has already waited.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (lock) begin
      cnt_q <= cnt_q;
    end else if (!valid || ready) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign boosted = (cnt_q == LIMIT);

endmodule

// File: rtl/int_writeback_arbiter.sv
// Integer writeback arbiter: picks at most one of three producers (MEM, MUL,
// ALU) per cycle and drives the register file write port through one
// register stage. Writes to x0 are consumed but not written.
//
// Build option: define WB_AGING_EN to add per-source wait counters; a source
// denied STARVE_LIMIT consecutive cycles beats all non-boosted sources.
// Without it, priority is strictly MEM > MUL > ALU.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   lock                     pipeline freeze, no grants while high
//   <src>_valid/addr/data    producer result (src = mem, mul, alu)
//   <src>_ready              combinational grant
//   write_enable1/addr1/data1  registered register file write port
//   grant_src                source of the current write (0 none, 1 MEM, 2 MUL, 3 ALU)
//
// Handshake: a producer raises valid with addr/data and holds all three
// stable until it sees ready; a transfer happens in the cycle where
// valid & ready are both 1. ready is never raised to a non-valid source and
// never depends on anything registered except the aging counters.
module int_writeback_arbiter #(
  parameter int WORD_W       = lagarto_wb_pkg::WORD_W,
  parameter int STARVE_LIMIT = lagarto_wb_pkg::STARVE_LIMIT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              lock,
  input  logic              mem_valid,
  input  logic [4:0]        mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              mul_valid,
  input  logic [4:0]        mul_addr,
  input  logic [WORD_W-1:0] mul_data,
  input  logic              alu_valid,
  input  logic [4:0]        alu_addr,
  input  logic [WORD_W-1:0] alu_data,
  output logic              mem_ready,
  output logic              mul_ready,
  output logic              alu_ready,
  output logic              write_enable1,
  output logic [4:0]        write_addr1,
  output logic [WORD_W-1:0] write_data1,
  output logic [1:0]        grant_src
);

  import lagarto_wb_pkg::*;

  logic [NUM_SRC-1:0] valid_v;
  logic [NUM_SRC-1:0] cand_v;
  logic [NUM_SRC-1:0] grant_v;

  assign valid_v = {alu_valid, mul_valid, mem_valid};

`ifdef WB_AGING_EN
  logic [NUM_SRC-1:0] boost_v;
  logic [NUM_SRC-1:0] boost_req;

  wb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_cnt_mem (
    .CLK     (CLK),
    .RST     (RST),
    .lock    (lock),
    .valid   (mem_valid),
    .ready   (grant_v[0]),
    .boosted (boost_v[0])
  );

  wb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_cnt_mul (
    .CLK     (CLK),
    .RST     (RST),
    .lock    (lock),
    .valid   (mul_valid),
    .ready   (grant_v[1]),
    .boosted (boost_v[1])
  );

  wb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_cnt_alu (
    .CLK     (CLK),
    .RST     (RST),
    .lock    (lock),
    .valid   (alu_valid),
    .ready   (grant_v[2]),
    .boosted (boost_v[2])
  );

  // A counter can sit at the limit in the cycle its source drops valid, so
  // boost only counts for sources that are requesting now. If any boosted
  // source requests, only boosted sources compete (base priority among them).
  assign boost_req = valid_v & boost_v;
  assign cand_v    = (|boost_req) ? boost_req : valid_v;
`else
  assign cand_v = valid_v;
`endif

  assign grant_v   = (RST || lock) ? '0 : first_req(cand_v);
  assign mem_ready = grant_v[0];
  assign mul_ready = grant_v[1];
  assign alu_ready = grant_v[2];

  logic [4:0]        sel_addr;
  logic [WORD_W-1:0] sel_data;
  wb_src_e           sel_src;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_src  = SRC_NONE;
    if (grant_v[0]) begin
      sel_addr = mem_addr;
      sel_data = mem_data;
      sel_src  = SRC_MEM;
    end else if (grant_v[1]) begin
      sel_addr = mul_addr;
      sel_data = mul_data;
      sel_src  = SRC_MUL;
    end else if (grant_v[2]) begin
      sel_addr = alu_addr;
      sel_data = alu_data;
      sel_src  = SRC_ALU;
    end
  end

  // Output stage. Address and data hold across idle cycles so the port only
  // toggles on real grants; the enable alone qualifies them. An x0 grant
  // still loads addr/data/source but leaves the enable low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      write_enable1 <= 1'b0;
      write_addr1   <= '0;
      write_data1   <= '0;
      grant_src     <= SRC_NONE;
    end else if (|grant_v) begin
      write_enable1 <= (sel_addr != 5'd0);
      write_addr1   <= sel_addr;
      write_data1   <= sel_data;
      grant_src     <= sel_src;
    end else begin
      write_enable1 <= 1'b0;
      grant_src     <= SRC_NONE;
    end
  end

endmodule

// File: tb/tb_int_writeback_arbiter.sv
// Self-checking bench for int_writeback_arbiter: directed scenarios followed
// by randomized producer traffic, all compared against a cycle-level model.
// Works with or without WB_AGING_EN defined.
module tb_int_writeback_arbiter;

  localparam int W   = 64;
  localparam int LIM = 3;

  logic         CLK;
  logic         RST;
  logic         lock;
  logic         mem_valid, mul_valid, alu_valid;
  logic [4:0]   mem_addr, mul_addr, alu_addr;
  logic [W-1:0] mem_data, mul_data, alu_data;
  logic         mem_ready, mul_ready, alu_ready;
  logic         write_enable1;
  logic [4:0]   write_addr1;
  logic [W-1:0] write_data1;
  logic [1:0]   grant_src;

  int_writeback_arbiter #(.WORD_W(W), .STARVE_LIMIT(LIM)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .lock          (lock),
    .mem_valid     (mem_valid),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mul_valid     (mul_valid),
    .mul_addr      (mul_addr),
    .mul_data      (mul_data),
    .alu_valid     (alu_valid),
    .alu_addr      (alu_addr),
    .alu_data      (alu_data),
    .mem_ready     (mem_ready),
    .mul_ready     (mul_ready),
    .alu_ready     (alu_ready),
    .write_enable1 (write_enable1),
    .write_addr1   (write_addr1),
    .write_data1   (write_data1),
    .grant_src     (grant_src)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- producer state (index 0 MEM, 1 MUL, 2 ALU) ----------------
  logic         pv[3];
  logic [4:0]   pa[3];
  logic [W-1:0] pd[3];

  // ---------------- reference model state ----------------
  int           wait_c[3];
  logic         e_we;
  logic [4:0]   e_addr;
  logic [W-1:0] e_data;
  logic [1:0]   e_src;
  logic [W+4:0] exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   last_win;
  logic r_mem, r_mul, r_alu;

  // ---------------- driver tasks ----------------
  task automatic drive();
    mem_valid = pv[0]; mem_addr = pa[0]; mem_data = pd[0];
    mul_valid = pv[1]; mul_addr = pa[1]; mul_data = pd[1];
    alu_valid = pv[2]; alu_addr = pa[2]; alu_data = pd[2];
  endtask

  task automatic set_src(input int i, input logic v, input logic [4:0] a, input logic [W-1:0] d);
    pv[i] = v;
    pa[i] = a;
    pd[i] = d;
    drive();
  endtask

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Winner index for the current inputs, -1 if nobody is granted.
  function automatic int ref_pick();
    if (RST || lock) return -1;
`ifdef WB_AGING_EN
    for (int i = 0; i < 3; i++)
      if (pv[i] && wait_c[i] >= LIM) return i;
`endif
    for (int i = 0; i < 3; i++)
      if (pv[i]) return i;
    return -1;
  endfunction

  task automatic ref_update(input int w);
    if (RST) begin
      e_we = 1'b0; e_addr = '0; e_data = '0; e_src = 2'd0;
      for (int i = 0; i < 3; i++) wait_c[i] = 0;
      return;
    end
    if (w >= 0) begin
      e_we   = (pa[w] != 5'd0);
      e_addr = pa[w];
      e_data = pd[w];
      e_src  = 2'(w + 1);
      if (e_we) exp_q.push_back({pa[w], pd[w]});
    end else begin
      e_we  = 1'b0;
      e_src = 2'd0;
    end
    if (!lock) begin
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] || i == w) wait_c[i] = 0;
        else if (wait_c[i] < LIM) wait_c[i] = wait_c[i] + 1;
      end
    end
  endtask

  // One clock cycle: check grants mid-cycle, advance the model at the edge,
  // check the registered write port just after the edge.
  task automatic run_cycle();
    int w;
    logic [W+4:0] ent;
    @(negedge CLK);
    w = ref_pick();
    r_mem = mem_ready; r_mul = mul_ready; r_alu = alu_ready;
    chk("mem_ready", W'(mem_ready), W'(w == 0));
    chk("mul_ready", W'(mul_ready), W'(w == 1));
    chk("alu_ready", W'(alu_ready), W'(w == 2));
    last_win = w;
    @(posedge CLK);
    ref_update(w);
    #1;
    chk("write_enable1", W'(write_enable1), W'(e_we));
    chk("write_addr1",   W'(write_addr1),   W'(e_addr));
    chk("write_data1",   write_data1,       e_data);
    chk("grant_src",     W'(grant_src),     W'(e_src));
    if (write_enable1) begin
      chk("wb_queue_nonempty", W'(exp_q.size() > 0), W'(1));
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        chk("wb_queue_addr", W'(write_addr1), W'(ent[W+4:W]));
        chk("wb_queue_data", write_data1, ent[W-1:0]);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b1;
    lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; wait_c[i] = 0;
    end
    e_we = 1'b0; e_addr = '0; e_data = '0; e_src = 2'd0;
    drive();

    // reset state
    run_cycle();
    run_cycle();
    chk("reset_we",  W'(write_enable1), W'(0));
    chk("reset_src", W'(grant_src), W'(0));
    RST = 1'b0;
    run_cycle();

    // single ALU result
    set_src(2, 1'b1, 5'd5, 64'h1234);
    run_cycle();
    chk("t1_alu_ready", W'(r_alu), W'(1));
    chk("t1_we",   W'(write_enable1), W'(1));
    chk("t1_addr", W'(write_addr1), W'(5));
    chk("t1_data", write_data1, 64'h1234);
    chk("t1_src",  W'(grant_src), W'(3));
    set_src(2, 1'b0, 5'd0, '0);
    run_cycle();

    // MEM and ALU together: MEM first, ALU next cycle
    set_src(0, 1'b1, 5'd3, 64'hAAAA_0003);
    set_src(2, 1'b1, 5'd4, 64'hBBBB_0004);
    run_cycle();
    chk("t2_mem_ready", W'(r_mem), W'(1));
    chk("t2_alu_ready", W'(r_alu), W'(0));
    chk("t2_addr3", W'(write_addr1), W'(3));
    set_src(0, 1'b0, 5'd0, '0);
    run_cycle();
    chk("t2_alu_next", W'(r_alu), W'(1));
    chk("t2_addr4", W'(write_addr1), W'(4));
    chk("t2_we4", W'(write_enable1), W'(1));
    set_src(2, 1'b0, 5'd0, '0);

    // x0 destination from MUL
    set_src(1, 1'b1, 5'd0, 64'hDEAD);
    run_cycle();
    chk("t3_mul_ready", W'(r_mul), W'(1));
    chk("t3_we", W'(write_enable1), W'(0));
    chk("t3_src", W'(grant_src), W'(2));
    set_src(1, 1'b0, 5'd0, '0);
    run_cycle();

    // lock with all three valid
    set_src(0, 1'b1, 5'd10, 64'h10);
    set_src(1, 1'b1, 5'd11, 64'h11);
    set_src(2, 1'b1, 5'd12, 64'h12);
    lock = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run_cycle();
      chk("t4_lock_noready", W'({r_mem, r_mul, r_alu}), W'(0));
      chk("t4_lock_we", W'(write_enable1), W'(0));
    end
    lock = 1'b0;
    run_cycle();
    chk("t4_unlock_mem", W'(r_mem), W'(1));
    set_src(0, 1'b0, 5'd0, '0);
    run_cycle();
    set_src(1, 1'b0, 5'd0, '0);
    run_cycle();
    set_src(2, 1'b0, 5'd0, '0);
    run_cycle();

    // starvation: MEM and ALU continuously valid
    set_src(0, 1'b1, 5'($urandom_range(1, 31)), rand_word());
    set_src(2, 1'b1, 5'($urandom_range(1, 31)), rand_word());
    for (int k = 0; k < 8; k++) begin
      run_cycle();
`ifdef WB_AGING_EN
      chk("t5_age_alu", W'(r_alu), W'(k == 3 || k == 7));
`else
      chk("t5_fixed_alu", W'(r_alu), W'(0));
`endif
      if (last_win == 0) set_src(0, 1'b1, 5'($urandom_range(1, 31)), rand_word());
      if (last_win == 2) set_src(2, 1'b1, 5'($urandom_range(1, 31)), rand_word());
    end
    for (int i = 0; i < 3; i++) set_src(i, 1'b0, 5'd0, '0);
    run_cycle();

    // reset the cycle after a grant, with ALU already partly aged
    set_src(0, 1'b1, 5'd7, 64'h77);
    set_src(2, 1'b1, 5'd8, 64'h88);
    run_cycle();
    set_src(0, 1'b1, 5'd9, 64'h99);
    run_cycle();
    set_src(0, 1'b1, 5'd13, 64'h1313);
    RST = 1'b1;
    run_cycle();
    chk("t6_rst_noready", W'({r_mem, r_mul, r_alu}), W'(0));
    chk("t6_rst_we", W'(write_enable1), W'(0));
    chk("t6_rst_src", W'(grant_src), W'(0));
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      run_cycle();
`ifdef WB_AGING_EN
      chk("t6_age_after_rst", W'(r_alu), W'(k == 3));
`else
      chk("t6_fixed_after_rst", W'(r_alu), W'(0));
`endif
      if (last_win == 0) set_src(0, 1'b1, 5'($urandom_range(1, 31)), rand_word());
      if (last_win == 2) set_src(2, 1'b1, 5'($urandom_range(1, 31)), rand_word());
    end

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pv[i] || last_win == i) begin
          pv[i] = ($urandom_range(0, 99) < 65);
          pa[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          pd[i] = rand_word();
        end
      end
      drive();
      lock = ($urandom_range(0, 9) == 0);
      RST  = ($urandom_range(0, 59) == 0);
      run_cycle();
    end
    RST = 1'b0;
    lock = 1'b0;
    for (int i = 0; i < 3; i++) set_src(i, 1'b0, 5'd0, '0);
    run_cycle();
    run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
